// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding/stall-flush controller for the in-order pipeline: shadow pipeline of in-flight
// destinations, load-use stall, redirect flush, multicycle-EX hold. PIPE_HAZARD_PERF_EN adds counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int N_STAGES   = 3,
    parameter int LOAD_LAT   = 2,
    parameter int SEL_W      = $clog2(N_STAGES + 1),
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_rs1_used,
    input  logic                  i_id_rs2_used,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_is_load,
    input  logic                  i_id_is_mc,
    input  logic                  i_ex_redirect,
    input  logic                  i_mc_done,
    output logic                  o_pc_hold,
    output logic                  o_ifid_hold,
    output logic                  o_ifid_flush,
    output logic                  o_idex_bubble,
    output logic                  o_ex_hold,
    output logic                  o_exmem_bubble,
    output logic [SEL_W-1:0]      o_fwd_sel_a,
    output logic [SEL_W-1:0]      o_fwd_sel_b,
`ifdef PIPE_HAZARD_PERF_EN
    output logic                  o_mc_start,
    output logic [CNT_W-1:0]      o_perf_stall_cnt,
    output logic [CNT_W-1:0]      o_perf_flush_cnt
`else
    output logic                  o_mc_start
`endif
);

    localparam int LR = 1 + LOAD_LAT;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  ld;
        logic                  mc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  rs1_used;
        logic                  rs2_used;
    } ent_t;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    ent_t            r_ent [1:N_STAGES];
    state_t          r_state, w_state_nxt;
    logic            r_after_rst;
    ent_t            w_id_ent;
    logic            w_quiet, w_mc_here, w_mc_start, w_hold_raw;
    logic            w_ex_hold, w_redirect, w_load_use, w_stall, w_idex_bubble;
    logic [SEL_W-1:0] w_sel_a, w_sel_b;

    function automatic logic f_match(ent_t e, logic [REG_ADDR_W-1:0] rs, logic used);
        return e.valid && e.wr && (e.rd != '0) && (e.rd == rs) && used;
    endfunction

    function automatic logic f_ready(ent_t e, int k);
        return k >= (e.ld ? LR : 2);
    endfunction

    // Outputs stay quiet during reset and for one cycle after it.
    assign w_quiet   = reset | r_after_rst;
    assign w_mc_here = r_ent[1].valid & r_ent[1].mc;

    always_comb begin
        w_id_ent = '0;
        if (i_id_valid) begin
            w_id_ent.valid    = 1'b1;
            w_id_ent.rd       = i_id_rd;
            w_id_ent.wr       = i_id_reg_write;
            w_id_ent.ld       = i_id_is_load;
            w_id_ent.mc       = i_id_is_mc;
            w_id_ent.rs1      = i_id_rs1;
            w_id_ent.rs2      = i_id_rs2;
            w_id_ent.rs1_used = i_id_rs1_used;
            w_id_ent.rs2_used = i_id_rs2_used;
        end
    end

    // A producer at stage k will sit at k+1 when the ID consumer reaches EX.
    always_comb begin
        w_load_use = 1'b0;
        for (int k = 1; k < N_STAGES; k++) begin
            if (i_id_valid && !f_ready(r_ent[k], k + 1) &&
                (f_match(r_ent[k], i_id_rs1, i_id_rs1_used) ||
                 f_match(r_ent[k], i_id_rs2, i_id_rs2_used)))
                w_load_use = 1'b1;
        end
    end

    // Walk from the oldest stage down so the youngest ready producer wins.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = N_STAGES; k >= 2; k--) begin
            if (r_ent[1].valid && f_ready(r_ent[k], k)) begin
                if (f_match(r_ent[k], r_ent[1].rs1, r_ent[1].rs1_used)) w_sel_a = SEL_W'(k);
                if (f_match(r_ent[k], r_ent[1].rs2, r_ent[1].rs2_used)) w_sel_b = SEL_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_mc_here && !i_mc_done) w_state_nxt = S_BUSY;
            S_BUSY:  if (i_mc_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mc_start = 1'b0;
        w_hold_raw = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mc_start = w_mc_here;
                w_hold_raw = w_mc_here & ~i_mc_done;
            end
            S_BUSY:  w_hold_raw = ~i_mc_done;
            default: w_hold_raw = 1'b0;
        endcase
    end

    assign w_ex_hold     = w_hold_raw & ~w_quiet;
    assign w_redirect    = i_ex_redirect & ~w_ex_hold & ~w_quiet;
    assign w_stall       = w_load_use & ~w_ex_hold & ~w_redirect & ~w_quiet;
    assign w_idex_bubble = w_redirect | w_stall;

    assign o_pc_hold      = w_ex_hold | w_stall;
    assign o_ifid_hold    = w_ex_hold | w_stall;
    assign o_ifid_flush   = w_redirect;
    assign o_idex_bubble  = w_idex_bubble;
    assign o_ex_hold      = w_ex_hold;
    assign o_exmem_bubble = w_ex_hold;
    assign o_mc_start     = w_mc_start & ~w_quiet;
    assign o_fwd_sel_a    = w_quiet ? '0 : w_sel_a;
    assign o_fwd_sel_b    = w_quiet ? '0 : w_sel_b;

    always_ff @(posedge clk) begin
        r_after_rst <= reset;
    end

    // On ex_hold the EX entry freezes and a hole opens behind it in stage 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= N_STAGES; k++) r_ent[k] <= '0;
        end else if (w_ex_hold) begin
            r_ent[2] <= '0;
            for (int k = 3; k <= N_STAGES; k++) r_ent[k] <= r_ent[k-1];
        end else begin
            r_ent[1] <= w_idex_bubble ? '0 : w_id_ent;
            for (int k = 2; k <= N_STAGES; k++) r_ent[k] <= r_ent[k-1];
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_pc_hold && !(&r_stall_cnt))    r_stall_cnt <= r_stall_cnt + 1'b1;
            if (o_ifid_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_perf_stall_cnt = r_stall_cnt;
    assign o_perf_flush_cnt = r_flush_cnt;
`endif

endmodule
